fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Program-counter and fetch controller for the 8-bit lab CPU. It drives the address of the combinational 8-bit instruction memory and registers each fetched instruction into an output slot for the decode stage, using a valid/ready handshake. It resolves unconditional jumps (opcode 2'b11) locally and accepts taken-branch redirects from execute. It halts at the end of the program.

Parameters:
ADDR_W, 8, PC and imem address width
INSTR_W, 8, instruction width
PROG_LEN, 32, first address past the program; a fetch that reaches it halts (1..2**ADDR_W)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; leaves IDLE and begins fetch at pc=0
imem_addr  out  ADDR_W  address to instruction memory; always equals pc
imem_instr  in  INSTR_W  combinational memory data for imem_addr
instr_out  out  INSTR_W  registered instruction to decode
instr_pc  out  ADDR_W  address instr_out was fetched from
instr_valid  out  1  instr_out holds an unconsumed instruction
instr_ready  in  1  decode accepts; transfer when valid&&ready
redirect_valid  in  1  taken branch; flush and refetch
redirect_pc  in  ADDR_W  branch target
halted  out  1  high in HALT state

Behaviour:
- Reset (sync, active-high): state=IDLE, pc=0, instr_out=0, instr_pc=0, instr_valid=0, halted=0. Reset mid-operation discards the slot contents immediately.
- States: IDLE, FETCH, HALT (2-bit encoding).
- IDLE: imem_addr=0. start -> FETCH. start is ignored in FETCH and HALT.
- FETCH: the slot may load when it is free (!instr_valid || instr_ready). On load at the clock edge: instr_out<=imem_instr, instr_pc<=pc, instr_valid<=1. Latency is one clock from pc to instr_valid. Sustained throughput is one instruction per cycle while ready is held high.
- Next pc on load:
  - If imem_instr[7:6]==2'b11 (jump): pc<={pc[7:6], imem_instr[5:0]}.
  - Otherwise: pc<=pc+1, modulo 2**ADDR_W.
- If the slot is not free, pc and the slot hold. instr_out must stay stable while valid && !ready.
- Transfer with no new load: instr_valid<=0.
- Halt: if the next pc equals PROG_LEN (non-jump increment only), the current instruction is still loaded, then state -> HALT and halted=1. In HALT no further loads occur. The pending slot drains normally via ready.
- Wrap: with PROG_LEN=2**ADDR_W the pc wraps 255->0 and never halts.
- redirect_valid has priority over load and halt, and is accepted in FETCH or HALT. Same cycle: pc<=redirect_pc, instr_valid<=0 (the slot is flushed even if ready is high), state -> FETCH, halted<=0. The first post-redirect instruction is valid one cycle later.
- redirect_valid is ignored in IDLE.
- A jump whose target is itself loops forever; this is not detected.
- reset has priority over redirect, which has priority over start and load.

Optional Feature:
FETCH_SINGLE_STEP_EN:
- Defined: adds input step (1 bit). In FETCH a load occurs only when step is high and the slot is free, giving at most one instruction per step pulse. redirect and halt are unchanged.
- Undefined: the port is absent and fetch is free-running as above.

Decomposition:
- Shared package/header: ADDR_W/INSTR_W defaults, OP_JUMP=2'b11, the opcode field position [7:6], the jump target field [5:0], and the state encodings ST_IDLE/ST_FETCH/ST_HALT.
- One natural sub-module: fetch_pc_next. It is combinational. Inputs are pc, imem_instr, redirect_valid and redirect_pc. Outputs are next_pc and hit_end (next_pc==PROG_LEN on the increment path).

Test Plan:
- Reset -> start, ready=1, program 0:8'h49, 1:8'h27, 2:8'h39. Expected: instr_valid rises one cycle after start+1 edge; instr_out sequence 49,27,39 on consecutive cycles; instr_pc 0,1,2.
- Jump: mem[10]=8'b11000011. Expected: after instr_pc=10 the next instr_pc is 3, and addresses 11+ are never presented.
- Backpressure: ready=0 for 3 cycles while instr_out=8'h27. Expected: instr_out, instr_pc and pc stay stable. When ready=1 the next instruction follows with no loss or duplication.
- Redirect: redirect_valid with redirect_pc=5, asserted while valid=1 and ready=0. Expected: next cycle valid=0; the following cycle instr_pc=5 with mem[5]=8'h32.
- End: PROG_LEN=4, straight-line code. Expected: instr_pc 0..3 are delivered, halted=1 after the load of 3, imem_addr holds 4, and no fifth valid. Then redirect_pc=0 leaves HALT and halted=0.
- Reset asserted mid-stream with valid=1. Expected: next cycle valid=0, pc=0, state IDLE, and start is required to resume.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the lab CPU fetch sequencer: widths, opcode fields and FSM encodings.
package fetch_sequencer_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 8;

    // Opcode lives in the top two instruction bits; jumps carry a 6-bit page-local target.
    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int TGT_W  = 6;
    localparam logic [1:0] OP_JUMP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    function automatic logic is_jump_op(input logic [1:0] opcode);
        return opcode == OP_JUMP;
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Combinational next-pc selection: redirect, local jump or increment, plus end-of-program detect.
module fetch_pc_next
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int PROG_LEN = 32
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               hit_end
);

    // One extra bit so that PROG_LEN == 2**ADDR_W can never match a wrapped pc.
    localparam logic [ADDR_W:0] END_PC = (ADDR_W+1)'(PROG_LEN);

    logic              is_jump;
    logic [ADDR_W-1:0] inc_pc;
    logic [ADDR_W-1:0] jump_pc;

    assign is_jump = is_jump_op(imem_instr[OP_HI:OP_LO]);
    assign inc_pc  = pc + ADDR_W'(1);

    // Jump keeps the current page bits and replaces the low field with the target.
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_jump_bits
        if (gi < TGT_W) begin : g_tgt
            assign jump_pc[gi] = imem_instr[gi];
        end else begin : g_page
            assign jump_pc[gi] = pc[gi];
        end
    end

    always_comb begin
        next_pc = inc_pc;
        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (is_jump) begin
            next_pc = jump_pc;
        end
    end

    assign hit_end = !redirect_valid && !is_jump && ({1'b0, inc_pc} == END_PC);

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller with a single valid/ready output slot.
// Optional FETCH_SINGLE_STEP_EN adds a step input gating each load.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int PROG_LEN = 32
) (
    input  logic               clk,
    input  logic               reset,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
);

    state_t             state_reg;
    logic [ADDR_W-1:0]  pc_reg;
    logic [INSTR_W-1:0] instr_out_reg;
    logic [ADDR_W-1:0]  instr_pc_reg;
    logic               instr_valid_reg;
    logic               halted_reg;

    logic [ADDR_W-1:0]  pc_next;
    logic               hit_end;
    logic               slot_free;
    logic               step_ok;
    logic               do_load;

`ifdef FETCH_SINGLE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    fetch_pc_next #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .PROG_LEN (PROG_LEN)
    ) u_pc_next (
        .pc             (pc_reg),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .next_pc        (pc_next),
        .hit_end        (hit_end)
    );

    assign slot_free = !instr_valid_reg || instr_ready;
    assign do_load   = (state_reg == ST_FETCH) && slot_free && step_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= '0;
            instr_out_reg   <= '0;
            instr_pc_reg    <= '0;
            instr_valid_reg <= 1'b0;
            halted_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_FETCH;
                    end
                end
                default: begin
                    // Redirect flushes the slot even if decode is taking it this cycle.
                    if (redirect_valid) begin
                        pc_reg          <= pc_next;
                        instr_valid_reg <= 1'b0;
                        state_reg       <= ST_FETCH;
                        halted_reg      <= 1'b0;
                    end else if (do_load) begin
                        instr_out_reg   <= imem_instr;
                        instr_pc_reg    <= pc_reg;
                        instr_valid_reg <= 1'b1;
                        pc_reg          <= pc_next;
                        if (hit_end) begin
                            state_reg  <= ST_HALT;
                            halted_reg <= 1'b1;
                        end
                    end else if (instr_valid_reg && instr_ready) begin
                        instr_valid_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign imem_addr   = pc_reg;
    assign instr_out   = instr_out_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = instr_valid_reg;
    assign halted      = halted_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: stream, jump, backpressure, redirect, end-of-program, reset.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, start_e;
    logic [7:0] imem_addr, imem_addr_e;
    logic [7:0] imem_instr, imem_instr_e;
    logic [7:0] instr_out, instr_out_e;
    logic [7:0] instr_pc, instr_pc_e;
    logic       instr_valid, instr_valid_e;
    logic       instr_ready, instr_ready_e;
    logic       redirect_valid, redirect_valid_e;
    logic [7:0] redirect_pc, redirect_pc_e;
    logic       halted, halted_e;

    logic [7:0] mem [256];
    int         total = 0;
    int         bad = 0;
    logic       jump_watch = 1'b0;
    logic       seen_past_jump = 1'b0;

    always #5 clk = ~clk;

    assign imem_instr   = mem[imem_addr];
    assign imem_instr_e = mem[imem_addr_e];

    fetch_sequencer #(.ADDR_W(8), .INSTR_W(8), .PROG_LEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    fetch_sequencer #(.ADDR_W(8), .INSTR_W(8), .PROG_LEN(4)) dut_end (
        .clk            (clk),
        .reset          (reset),
        .start          (start_e),
        .imem_addr      (imem_addr_e),
        .imem_instr     (imem_instr_e),
        .instr_out      (instr_out_e),
        .instr_pc       (instr_pc_e),
        .instr_valid    (instr_valid_e),
        .instr_ready    (instr_ready_e),
        .redirect_valid (redirect_valid_e),
        .redirect_pc    (redirect_pc_e),
        .halted         (halted_e)
    );

    always @(posedge clk) begin
        if (jump_watch && imem_addr > 8'd10) seen_past_jump <= 1'b1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (instr_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 8'h00 ||
            instr_out !== 8'h00 || instr_pc !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: valid=%b halted=%b addr=%h out=%h pc=%h, need 0 0 00 00 00",
                     instr_valid, halted, imem_addr, instr_out, instr_pc);
        end
        $display("reset: valid=%b halted=%b addr=%h", instr_valid, halted, imem_addr);
        reset = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 8'h07;
        tick();
        redirect_valid = 1'b0;
        tick();
        total++;
        if (instr_valid !== 1'b0 || imem_addr !== 8'h00) begin
            bad++;
            $display("FAIL idle_redirect_ignored: valid=%b addr=%h, need 0 00", instr_valid, imem_addr);
        end
        $display("idle redirect: valid=%b addr=%h", instr_valid, imem_addr);
    endtask

    task automatic test_stream_and_jump;
        logic [7:0] exp_out [11];
        logic [7:0] exp_pc  [11];
        exp_out = '{8'h49, 8'h27, 8'h39, 8'h13, 8'h14, 8'h32, 8'h16, 8'h17, 8'h18, 8'h19, 8'hC3};
        for (int k = 0; k < 11; k++) exp_pc[k] = 8'(k);
        start = 1'b1;
        instr_ready = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_latency: valid=%b, need 0", instr_valid);
        end
        jump_watch = 1'b1;
        for (int k = 0; k < 11; k++) begin
            tick();
            total++;
            if (instr_valid !== 1'b1 || instr_out !== exp_out[k] || instr_pc !== exp_pc[k]) begin
                bad++;
                $display("FAIL stream_%0d: valid=%b out=%h pc=%h, need 1 %h %h",
                         k, instr_valid, instr_out, instr_pc, exp_out[k], exp_pc[k]);
            end
            $display("fetch: pc=%h instr=%h", instr_pc, instr_out);
        end
        tick();
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h03 || instr_out !== 8'h13) begin
            bad++;
            $display("FAIL jump_target: valid=%b pc=%h out=%h, need 1 03 13", instr_valid, instr_pc, instr_out);
        end
        $display("after jump: pc=%h instr=%h", instr_pc, instr_out);
        tick();
        jump_watch = 1'b0;
        total++;
        if (instr_pc !== 8'h04 || seen_past_jump !== 1'b0) begin
            bad++;
            $display("FAIL jump_no_fallthrough: pc=%h past=%b, need 04 0", instr_pc, seen_past_jump);
        end
    endtask

    task automatic test_backpressure;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1;
        instr_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (instr_valid !== 1'b1 || instr_out !== 8'h27 || instr_pc !== 8'h01 || imem_addr !== 8'h02) begin
                bad++;
                $display("FAIL stall_%0d: valid=%b out=%h pc=%h addr=%h, need 1 27 01 02",
                         k, instr_valid, instr_out, instr_pc, imem_addr);
            end
            $display("stall: pc=%h instr=%h addr=%h", instr_pc, instr_out, imem_addr);
        end
        instr_ready = 1'b1;
        tick();
        total++;
        if (instr_valid !== 1'b1 || instr_out !== 8'h39 || instr_pc !== 8'h02) begin
            bad++;
            $display("FAIL stall_release: valid=%b out=%h pc=%h, need 1 39 02", instr_valid, instr_out, instr_pc);
        end
        tick();
        total++;
        if (instr_out !== 8'h13 || instr_pc !== 8'h03) begin
            bad++;
            $display("FAIL stall_follow: out=%h pc=%h, need 13 03", instr_out, instr_pc);
        end
        $display("resume: pc=%h instr=%h", instr_pc, instr_out);
    endtask

    task automatic test_redirect;
        instr_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 8'h05;
        tick();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        total++;
        if (instr_valid !== 1'b0 || imem_addr !== 8'h05) begin
            bad++;
            $display("FAIL redirect_flush: valid=%b addr=%h, need 0 05", instr_valid, imem_addr);
        end
        tick();
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h05 || instr_out !== 8'h32) begin
            bad++;
            $display("FAIL redirect_target: valid=%b pc=%h out=%h, need 1 05 32", instr_valid, instr_pc, instr_out);
        end
        $display("redirect: pc=%h instr=%h", instr_pc, instr_out);
        tick();
        total++;
        if (instr_pc !== 8'h06 || instr_out !== 8'h16) begin
            bad++;
            $display("FAIL redirect_follow: pc=%h out=%h, need 06 16", instr_pc, instr_out);
        end
    endtask

    task automatic test_end;
        start_e = 1'b1;
        instr_ready_e = 1'b1;
        tick();
        start_e = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (instr_valid_e !== 1'b1 || instr_pc_e !== 8'(k) || halted_e !== (k == 3)) begin
                bad++;
                $display("FAIL end_load_%0d: valid=%b pc=%h halted=%b, need 1 %h %b",
                         k, instr_valid_e, instr_pc_e, halted_e, 8'(k), (k == 3));
            end
            $display("end fetch: pc=%h halted=%b", instr_pc_e, halted_e);
        end
        total++;
        if (imem_addr_e !== 8'h04) begin
            bad++;
            $display("FAIL end_addr: addr=%h, need 04", imem_addr_e);
        end
        tick();
        tick();
        total++;
        if (instr_valid_e !== 1'b0 || halted_e !== 1'b1 || imem_addr_e !== 8'h04) begin
            bad++;
            $display("FAIL end_drained: valid=%b halted=%b addr=%h, need 0 1 04",
                     instr_valid_e, halted_e, imem_addr_e);
        end
        redirect_valid_e = 1'b1;
        redirect_pc_e = 8'h00;
        tick();
        redirect_valid_e = 1'b0;
        total++;
        if (halted_e !== 1'b0 || instr_valid_e !== 1'b0 || imem_addr_e !== 8'h00) begin
            bad++;
            $display("FAIL end_redirect: halted=%b valid=%b addr=%h, need 0 0 00",
                     halted_e, instr_valid_e, imem_addr_e);
        end
        tick();
        total++;
        if (instr_valid_e !== 1'b1 || instr_pc_e !== 8'h00 || instr_out_e !== 8'h49) begin
            bad++;
            $display("FAIL end_refetch: valid=%b pc=%h out=%h, need 1 00 49", instr_valid_e, instr_pc_e, instr_out_e);
        end
        $display("end redirect: pc=%h halted=%b", instr_pc_e, halted_e);
    endtask

    task automatic test_reset_mid;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || imem_addr !== 8'h00 || halted !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: valid=%b addr=%h halted=%b, need 0 00 0", instr_valid, imem_addr, halted);
        end
        tick();
        tick();
        total++;
        if (instr_valid !== 1'b0 || imem_addr !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset_idle: valid=%b addr=%h, need 0 00", instr_valid, imem_addr);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr_out !== 8'h49) begin
            bad++;
            $display("FAIL mid_reset_restart: valid=%b pc=%h out=%h, need 1 00 49", instr_valid, instr_pc, instr_out);
        end
        $display("restart: pc=%h instr=%h", instr_pc, instr_out);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(8'h10 + i);
        mem[0]  = 8'h49;
        mem[1]  = 8'h27;
        mem[2]  = 8'h39;
        mem[5]  = 8'h32;
        mem[10] = 8'b1100_0011;
        reset = 1'b1;
        start = 1'b0;
        start_e = 1'b0;
        instr_ready = 1'b0;
        instr_ready_e = 1'b0;
        redirect_valid = 1'b0;
        redirect_valid_e = 1'b0;
        redirect_pc = 8'h00;
        redirect_pc_e = 8'h00;

        test_reset();
        test_stream_and_jump();
        test_backpressure();
        test_redirect();
        test_end();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
